// File: rtl/posit_extract_pipe_es3.sv
// Purpose: unpack a 32-bit es=3 posit into sign, signed scale, 26-bit fraction and inf/zero flags.
// Latency: 3 cycles (S1 sign/abs/specials, S2 regime count, S3 shift and assemble); 1 word/cycle.
// Backpressure: one global advance = !out_valid || out_ready stalls every stage together; in_ready = advance.
module posit_extract_pipe_es3 #(
  parameter int NBITS = 32,
  parameter int ES    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [37:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // Bits left after the sign, the leading regime bit and its first follower.
  localparam int TW = NBITS - 3;
  // Fraction width: whatever trails the exponent field.
  localparam int FW = TW - ES;

  logic advance;

  // Stage 1 state: magnitude and special flags.
  logic          s1_vld_q, s1_vld_d;
  logic          s1_sgn_q, s1_sgn_d;
  logic          s1_zero_q, s1_zero_d;
  logic          s1_inf_q, s1_inf_d;
  logic [30:0]   s1_abs_q, s1_abs_d;

  // Stage 2 state: regime polarity, run length and the bits below the regime's first follower.
  logic          s2_vld_q, s2_vld_d;
  logic          s2_sgn_q, s2_sgn_d;
  logic          s2_zero_q, s2_zero_d;
  logic          s2_inf_q, s2_inf_d;
  logic          s2_rbit_q, s2_rbit_d;
  logic [4:0]    s2_m_q, s2_m_d;
  logic [TW-1:0] s2_body_q, s2_body_d;

  // Stage 3 state: the assembled output word.
  logic          s3_vld_q, s3_vld_d;
  logic [37:0]   s3_dat_q, s3_dat_d;

  // Combinational helpers.
  logic [30:0]   flip;
  logic [4:0]    lz;
  logic [TW-1:0] tail;
  logic [ES-1:0] exp_v;
  logic [FW-1:0] frac_v;
  logic [8:0]    k9;
  logic [8:0]    scale9;

  assign advance   = !s3_vld_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_vld_q;
  assign out_data  = s3_dat_q;

  // S1: detect the two special encodings, record sign, take two's-complement magnitude.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_sgn_d  = s1_sgn_q;
    s1_zero_d = s1_zero_q;
    s1_inf_d  = s1_inf_q;
    s1_abs_d  = s1_abs_q;
    if (advance) begin
      s1_vld_d  = in_valid;
      s1_sgn_d  = in_data[NBITS-1];
      s1_zero_d = (in_data == '0);
      s1_inf_d  = (in_data == {1'b1, {(NBITS-1){1'b0}}});
      // Only the low 31 bits of the magnitude matter; bit 31 is zero for every non-special word.
      s1_abs_d  = in_data[NBITS-1] ? (~in_data[30:0] + 31'd1) : in_data[30:0];
    end
  end

  // S2: regime run length = leading zeros after inverting a ones-run, so one counter serves both polarities.
  always_comb begin
    flip = s1_abs_q[30] ? ~s1_abs_q : s1_abs_q;
    lz   = 5'd31;
    for (int i = 0; i < 31; i++) begin
      if (flip[i]) lz = 5'(30 - i);
    end
    s2_vld_d  = s2_vld_q;
    s2_sgn_d  = s2_sgn_q;
    s2_zero_d = s2_zero_q;
    s2_inf_d  = s2_inf_q;
    s2_rbit_d = s2_rbit_q;
    s2_m_d    = s2_m_q;
    s2_body_d = s2_body_q;
    if (advance) begin
      s2_vld_d  = s1_vld_q;
      s2_sgn_d  = s1_sgn_q;
      s2_zero_d = s1_zero_q;
      s2_inf_d  = s1_inf_q;
      s2_rbit_d = s1_abs_q[30];
      s2_m_d    = lz;
      s2_body_d = s1_abs_q[TW-1:0];
    end
  end

  // S3: drop the rest of the regime and its terminator, split exponent/fraction, build the scale.
  always_comb begin
    // Run length m >= 1, so shifting the body left by m-1 discards exactly regime + terminator;
    // shifts of TW or more (m = 30, 31) leave zero, which zero-pads exponent and fraction.
    tail   = s2_body_q << (s2_m_q - 5'd1);
    exp_v  = tail[FW +: ES];
    frac_v = tail[FW-1:0];
    k9     = s2_rbit_q ? ({4'd0, s2_m_q} - 9'd1) : (9'd0 - {4'd0, s2_m_q});
    scale9 = (k9 << ES) + {{(9-ES){1'b0}}, exp_v};
    s3_vld_d = s3_vld_q;
    s3_dat_d = s3_dat_q;
    if (advance) begin
      s3_vld_d = s2_vld_q;
      if (s2_zero_q) begin
        s3_dat_d = 38'd1;
      end else if (s2_inf_q) begin
        s3_dat_d = {1'b1, 35'd0, 2'b10};
      end else begin
        s3_dat_d = {s2_sgn_q, scale9, frac_v, 2'b00};
      end
    end
  end

  // Pipeline registers; reset drops every in-flight word and clears the output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_sgn_q  <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_abs_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_sgn_q  <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_rbit_q <= 1'b0;
      s2_m_q    <= '0;
      s2_body_q <= '0;
      s3_vld_q  <= 1'b0;
      s3_dat_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sgn_q  <= s1_sgn_d;
      s1_zero_q <= s1_zero_d;
      s1_inf_q  <= s1_inf_d;
      s1_abs_q  <= s1_abs_d;
      s2_vld_q  <= s2_vld_d;
      s2_sgn_q  <= s2_sgn_d;
      s2_zero_q <= s2_zero_d;
      s2_inf_q  <= s2_inf_d;
      s2_rbit_q <= s2_rbit_d;
      s2_m_q    <= s2_m_d;
      s2_body_q <= s2_body_d;
      s3_vld_q  <= s3_vld_d;
      s3_dat_q  <= s3_dat_d;
    end
  end

endmodule

// File: tb/tb_posit_extract_pipe_es3.sv
// Bench for posit_extract_pipe_es3: directed decode table, streaming, backpressure, reset mid-stream, random.
// Expected words come from hand constants or a bit-walking posit decoder; a queue decouples driver and monitor.
// out_ready is driven by the bench, either held or randomly toggled.
module tb_posit_extract_pipe_es3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [37:0] out_data;
  logic        out_valid;
  logic        out_ready;

  posit_extract_pipe_es3 #(.NBITS(32), .ES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [37:0] dat;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          cur_lat = 1'b0;
  bit          cur_use = 1'b0;
  logic [37:0] cur_exp = '0;
  bit          rnd_bp  = 1'b0;

  task automatic chk(input string name, input logic [37:0] got, input logic [37:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference decoder: walk the regime bit by bit, then peel exponent and fraction off the remainder.
  function automatic logic [37:0] ref_decode(input logic [31:0] w);
    logic [31:0] a, remv, fb;
    logic        r, stop;
    int          m, k, rem, e, scale;
    logic [25:0] frac;
    logic [8:0]  sc9;
    if (w == 32'h0000_0000) return 38'd1;
    if (w == 32'h8000_0000) return {1'b1, 35'd0, 2'b10};
    a = w[31] ? -w : w;
    r = a[30];
    m = 0;
    stop = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!stop) begin
        if (a[i] == r) m++;
        else stop = 1'b1;
      end
    end
    k   = r ? m - 1 : -m;
    rem = (m >= 30) ? 0 : 30 - m;
    remv = a & ((32'd1 << rem) - 32'd1);
    if (rem >= 3) begin
      e    = int'(remv >> (rem - 3));
      fb   = remv & ((32'd1 << (rem - 3)) - 32'd1);
      frac = 26'(fb << (29 - rem));
    end else begin
      e    = int'(remv << (3 - rem));
      frac = '0;
    end
    scale = 8 * k + e;
    sc9   = 9'(scale);
    return {w[31], sc9, frac, 2'b00};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 2))
      0:       w = $urandom;
      1:       w = $urandom >> $urandom_range(1, 31);
      default: w = ~($urandom >> $urandom_range(1, 31));
    endcase
    if ($urandom_range(0, 3) == 0) w = -w;
    return w;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stimulus side of the scoreboard: record the expected result of every accepted word.
  initial begin
    exp_t pe;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        pe.dat = cur_use ? cur_exp : ref_decode(in_data);
        pe.cyc = cyc;
        pe.lat = cur_lat;
        sb.push_back(pe);
      end
    end
  end

  // Monitor: handshake rule, hold-while-stalled, in-order result check and latency.
  initial begin
    exp_t        po;
    logic        prev_v = 1'b0, prev_r = 1'b1, prev_rst = 1'b1;
    logic [37:0] prev_d = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        chk("in_ready", {37'd0, in_ready}, {37'd0, (!out_valid || out_ready)});
        if (!prev_rst && prev_v && !prev_r) begin
          chk("hold_valid", {37'd0, out_valid}, 38'd1);
          chk("hold_data", out_data, prev_d);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %h expected no output (cycle %0d)", out_data, cyc);
          end else begin
            po = sb.pop_front();
            chk("data", out_data, po.dat);
            if (po.lat) chk("latency", 38'(cyc - po.cyc), 38'd3);
          end
        end
      end
      prev_v   = out_valid;
      prev_r   = out_ready;
      prev_d   = out_data;
      prev_rst = reset;
    end
  end

  task automatic send(input logic [31:0] d, input bit lat, input bit use_exp, input logic [37:0] ex);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    cur_lat  = lat;
    cur_use  = use_exp;
    cur_exp  = ex;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready && !reset) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected accept of %h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", 38'(sb.size()), 38'd0);
  endtask

  logic [31:0] dir_in  [9];
  logic [37:0] dir_exp [9];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_in[0] = 32'h4000_0000; dir_exp[0] = 38'h00_0000_0000;
    dir_in[1] = 32'h4800_0000; dir_exp[1] = 38'h00_2000_0000;
    dir_in[2] = 32'hC000_0000; dir_exp[2] = 38'h20_0000_0000;
    dir_in[3] = 32'h4200_0000; dir_exp[3] = 38'h00_0800_0000;
    dir_in[4] = 32'h4000_0001; dir_exp[4] = 38'h00_0000_0004;
    dir_in[5] = 32'h7FFF_FFFF; dir_exp[5] = 38'h0F_0000_0000;
    dir_in[6] = 32'h0000_0001; dir_exp[6] = 38'h11_0000_0000;
    dir_in[7] = 32'h0000_0000; dir_exp[7] = 38'h00_0000_0001;
    dir_in[8] = 32'h8000_0000; dir_exp[8] = 38'h20_0000_0002;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {37'd0, out_valid}, 38'd0);
    chk("reset_out_data", out_data, 38'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed decodes, issued back to back with latency checking.
    for (int i = 0; i < 9; i++) send(dir_in[i], 1'b1, 1'b1, dir_exp[i]);
    drain();

    // Eight consecutive random words with out_ready held high.
    for (int i = 0; i < 8; i++) send(rand_word(), 1'b1, 1'b0, '0);
    drain();

    // Fill the pipe with out_ready low, stall five cycles, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_word(), 1'b0, 1'b0, '0);
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 4; i++) send(rand_word(), 1'b0, 1'b0, '0);
    drain();

    // Reset with three words in flight: none may emerge afterwards.
    for (int i = 0; i < 3; i++) send(rand_word(), 1'b0, 1'b0, '0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_out_valid", {37'd0, out_valid}, 38'd0);
    chk("midreset_out_data", out_data, 38'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    drain();
    for (int i = 0; i < 3; i++) send(rand_word(), 1'b1, 1'b0, '0);
    drain();

    // Random traffic with random gaps and random downstream stalls.
    rnd_bp = 1'b1;
    fork
      begin
        while (rnd_bp) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(rand_word(), 1'b0, 1'b0, '0);
    end
    rnd_bp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
